// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order queue of fetch-time branch predictions.
// At execute it compares the oldest prediction with the real outcome. It then
// drives the predictor update port, and on a mispredict it drives flush and
// redirect.
// Optional build macro: BRQ_STATS_EN adds the saturating counters
// stat_branches and stat_mispredicts.
// Handshakes: a push is taken when push_valid && push_ready. push_ready
// depends only on the registered count. A resolve is taken when
// res_valid && !empty. Both take effect on the rising clk edge.
module branch_resolve_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 64,
    parameter int IDX_W = 5
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [PC_W-1:0]          push_pc,
    input  logic                     push_pred_taken,
    input  logic [PC_W-1:0]          push_pred_target,
    input  logic                     res_valid,
    input  logic                     res_taken,
    input  logic [PC_W-1:0]          res_target,
    output logic                     upd_valid,
    output logic [IDX_W-1:0]         upd_addr,
    output logic                     upd_taken,
    output logic                     flush,
    output logic [PC_W-1:0]          redirect_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
`ifdef BRQ_STATS_EN
    ,
    output logic [31:0]              stat_branches,
    output logic [31:0]              stat_mispredicts
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PC_W-1:0]  PC_STEP  = PC_W'(4);

    logic [PC_W-1:0]  mem_pc   [DEPTH];
    logic             mem_pred [DEPTH];
    logic [PC_W-1:0]  mem_tgt  [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt_q;

    logic             do_push;
    logic             do_res;
    logic             mispredict;
    logic [PC_W-1:0]  head_pc;
    logic             head_pred;
    logic [PC_W-1:0]  head_tgt;
    logic [PC_W-1:0]  correct_pc;

    assign count      = cnt_q;
    assign empty      = (cnt_q == '0);
    assign push_ready = (cnt_q != FULL_CNT);
    assign do_push    = push_valid && push_ready;
    assign do_res     = res_valid && !empty;

    assign head_pc    = mem_pc[rd_ptr];
    assign head_pred  = mem_pred[rd_ptr];
    assign head_tgt   = mem_tgt[rd_ptr];

    // Wrong direction, or right "taken" direction but wrong target.
    assign mispredict = (head_pred != res_taken) ||
                        (head_pred && res_taken && (head_tgt != res_target));
    assign correct_pc = res_taken ? res_target : head_pc + PC_STEP;

    // Entry storage. A push in the same cycle as a mispredict is on the wrong path and is dropped.
    always_ff @(posedge clk) begin
        if (do_push && !(do_res && mispredict)) begin
            mem_pc[wr_ptr]   <= push_pc;
            mem_pred[wr_ptr] <= push_pred_taken;
            mem_tgt[wr_ptr]  <= push_pred_target;
        end
    end

    // Pointers and occupancy. A mispredict empties the queue by snapping rd_ptr to wr_ptr.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt_q  <= '0;
        end else if (do_res && mispredict) begin
            rd_ptr <= wr_ptr;
            cnt_q  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_res)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_res})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Registered resolve results: one-cycle update/flush pulses; redirect_pc holds between flushes.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            upd_valid   <= 1'b0;
            upd_addr    <= '0;
            upd_taken   <= 1'b0;
            flush       <= 1'b0;
            redirect_pc <= '0;
        end else begin
            upd_valid <= do_res;
            flush     <= do_res && mispredict;
            if (do_res) begin
                upd_addr  <= head_pc[IDX_W+1:2];
                upd_taken <= res_taken;
            end
            if (do_res && mispredict) begin
                redirect_pc <= correct_pc;
            end
        end
    end

`ifdef BRQ_STATS_EN
    // Saturating resolution and mispredict counters, updated on the popping edge.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (do_res) begin
            if (stat_branches != 32'hFFFF_FFFF) stat_branches <= stat_branches + 32'd1;
            if (mispredict && (stat_mispredicts != 32'hFFFF_FFFF)) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: directed scenarios plus a randomized phase,
// checked against a queue-based reference model and an expected-update scoreboard.
module tb_branch_resolve_queue;

    localparam int DEPTH = 4;
    localparam int PC_W  = 64;
    localparam int IDX_W = 5;
    localparam int EXP_W = IDX_W + 2 + PC_W;

    logic              clk;
    logic              arst_n;
    logic              push_valid;
    logic              push_ready;
    logic [PC_W-1:0]   push_pc;
    logic              push_pred_taken;
    logic [PC_W-1:0]   push_pred_target;
    logic              res_valid;
    logic              res_taken;
    logic [PC_W-1:0]   res_target;
    logic              upd_valid;
    logic [IDX_W-1:0]  upd_addr;
    logic              upd_taken;
    logic              flush;
    logic [PC_W-1:0]   redirect_pc;
    logic [2:0]        count;
    logic              empty;
`ifdef BRQ_STATS_EN
    logic [31:0]       stat_branches;
    logic [31:0]       stat_mispredicts;
`endif

    branch_resolve_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .IDX_W(IDX_W)) dut (
        .clk              (clk),
        .arst_n           (arst_n),
        .push_valid       (push_valid),
        .push_ready       (push_ready),
        .push_pc          (push_pc),
        .push_pred_taken  (push_pred_taken),
        .push_pred_target (push_pred_target),
        .res_valid        (res_valid),
        .res_taken        (res_taken),
        .res_target       (res_target),
        .upd_valid        (upd_valid),
        .upd_addr         (upd_addr),
        .upd_taken        (upd_taken),
        .flush            (flush),
        .redirect_pc      (redirect_pc),
        .count            (count),
        .empty            (empty)
`ifdef BRQ_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [PC_W-1:0] pc;
        logic            pt;
        logic [PC_W-1:0] tgt;
    } ent_t;

    ent_t             mq[$];
    logic [EXP_W-1:0] exp_q[$];
    logic [PC_W-1:0]  m_redirect;
    int unsigned      m_branches;
    int unsigned      m_mispredicts;

    int checks;
    int errors;

    task automatic chk(input string name, input logic [PC_W-1:0] got, input logic [PC_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (arst_n) begin
            if (upd_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL upd_unexpected: got addr %h taken %b flush %b, expected no update",
                             upd_addr, upd_taken, flush);
                end else begin
                    logic [EXP_W-1:0] e;
                    e = exp_q.pop_front();
                    if ({upd_addr, upd_taken, flush, redirect_pc} !== e) begin
                        errors++;
                        $display("FAIL upd_result: got addr %h taken %b flush %b redirect %h, expected addr %h taken %b flush %b redirect %h",
                                 upd_addr, upd_taken, flush, redirect_pc,
                                 e[EXP_W-1 -: IDX_W], e[PC_W+1], e[PC_W], e[PC_W-1:0]);
                    end
                end
            end else begin
                chk("flush_without_update", {63'd0, flush}, 64'd0);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic cycle(input logic pv, input logic [PC_W-1:0] ppc, input logic ppt,
                         input logic [PC_W-1:0] ptgt, input logic rv, input logic rt,
                         input logic [PC_W-1:0] rtgt);
        bit              acc_push;
        bit              acc_res;
        bit              mis;
        ent_t            h;
        ent_t            n;
        logic [PC_W-1:0] cpc;
        push_valid       = pv;
        push_pc          = ppc;
        push_pred_taken  = ppt;
        push_pred_target = ptgt;
        res_valid        = rv;
        res_taken        = rt;
        res_target       = rtgt;
        acc_push = pv && (mq.size() < DEPTH);
        acc_res  = rv && (mq.size() > 0);
        mis      = 1'b0;
        if (acc_res) begin
            h   = mq[0];
            mis = (h.pt != rt) || (h.pt && rt && h.tgt != rtgt);
            cpc = rt ? rtgt : h.pc + 64'd4;
            m_branches++;
            if (mis) begin
                m_mispredicts++;
                m_redirect = cpc;
                mq.delete();
            end else begin
                void'(mq.pop_front());
            end
            exp_q.push_back({h.pc[IDX_W+1:2], rt, mis, m_redirect});
        end
        if (acc_push && !(acc_res && mis)) begin
            n.pc  = ppc;
            n.pt  = ppt;
            n.tgt = ptgt;
            mq.push_back(n);
        end
        @(posedge clk);
        @(negedge clk);
        chk("count", {61'd0, count}, 64'(mq.size()));
        chk("empty", {63'd0, empty}, {63'd0, mq.size() == 0});
        chk("push_ready", {63'd0, push_ready}, {63'd0, mq.size() != DEPTH});
`ifdef BRQ_STATS_EN
        chk("stat_branches", {32'd0, stat_branches}, {32'd0, m_branches});
        chk("stat_mispredicts", {32'd0, stat_mispredicts}, {32'd0, m_mispredicts});
`endif
    endtask

    task automatic push(input logic [PC_W-1:0] pc, input logic pt, input logic [PC_W-1:0] tgt);
        cycle(1'b1, pc, pt, tgt, 1'b0, 1'b0, '0);
    endtask

    task automatic resolve(input logic rt, input logic [PC_W-1:0] rtgt);
        cycle(1'b0, '0, 1'b0, '0, 1'b1, rt, rtgt);
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_redirect    = '0;
        m_branches    = 0;
        m_mispredicts = 0;
    endtask

    // Called just after a falling edge: reset asserted between edges, checked at once.
    task automatic apply_reset();
        #2 arst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_count", {61'd0, count}, 64'd0);
        chk("rst_empty", {63'd0, empty}, 64'd1);
        chk("rst_push_ready", {63'd0, push_ready}, 64'd1);
        chk("rst_flush", {63'd0, flush}, 64'd0);
        chk("rst_upd_valid", {63'd0, upd_valid}, 64'd0);
        chk("rst_redirect", redirect_pc, 64'd0);
        @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks = 0;
        errors = 0;
        arst_n = 1'b0;
        push_valid = 1'b0; push_pc = '0; push_pred_taken = 1'b0; push_pred_target = '0;
        res_valid = 1'b0;  res_taken = 1'b0; res_target = '0;
        model_reset();
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        idle();

        // Wrap/order: 10 correct not-taken push/resolve pairs.
        for (int i = 0; i < 10; i++) begin
            push(64'(i * 4), 1'b0, '0);
            resolve(1'b0, '0);
        end
`ifdef BRQ_STATS_EN
        chk("stat_branches_ten", {32'd0, stat_branches}, 64'd10);
`endif
        idle();

        // Correct not-taken.
        push(64'h40, 1'b0, '0);
        resolve(1'b0, '0);
        idle();

        // Target mispredict.
        push(64'h80, 1'b1, 64'h100);
        resolve(1'b1, 64'h200);
        chk("redirect_target_mis", redirect_pc, 64'h200);
        idle();

        // Direction mispredict flushing younger entries plus a same-cycle push.
        push(64'h44, 1'b1, 64'h80);
        push(64'h60, 1'b0, '0);
        push(64'h64, 1'b0, '0);
        cycle(1'b1, 64'h70, 1'b0, '0, 1'b1, 1'b0, '0);
        chk("redirect_dir_mis", redirect_pc, 64'h48);
        idle();
        idle();
        chk("redirect_hold", redirect_pc, 64'h48);

        // Full boundary.
        for (int i = 0; i < 4; i++) push(64'h100 + 64'(i * 4), 1'b0, '0);
        push(64'h200, 1'b0, '0);
        cycle(1'b1, 64'h300, 1'b0, '0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) resolve(1'b0, '0);
        resolve(1'b0, '0);

        // Reset mid-stream with two entries queued, then an ignored resolve.
        push(64'h500, 1'b0, '0);
        push(64'h504, 1'b1, 64'h600);
        apply_reset();
        resolve(1'b1, 64'h600);
        idle();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [PC_W-1:0] pc;
            logic [PC_W-1:0] pt_tgt;
            logic [PC_W-1:0] r_tgt;
            pc     = 64'($urandom_range(0, 255)) << 2;
            pt_tgt = ($urandom_range(0, 1) != 0) ? 64'h1000 : 64'h2000;
            r_tgt  = ($urandom_range(0, 3) != 0) ? 64'h1000 : 64'h2000;
            cycle($urandom_range(0, 3) != 0, pc, $urandom_range(0, 1) != 0, pt_tgt,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 1) != 0, r_tgt);
        end

        idle();
        idle();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
